xc_aessub_seq: RTL

- Sequential, parametrised AES SubBytes functional unit for the XCrypto `xc.aessub.*` instruction family in the SCARV CPU execute stage.
- Supports all four variants (enc/dec × rot/no-rot) in one block.
- Time-multiplexes a configurable number of S-box lanes over the four result bytes, trading latency against area.
- Uses the core's valid/ready functional-unit handshake and supports pipeline flush.

---
 rtl/xc_aessub_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/xc_aessub_seq.sv
// AES SubBytes unit for xc.aessub.* (enc/dec, optional rotate), LANES S-box lanes reused over 4 bytes.
// Latency: operands captured in IDLE, 4/LANES RUN cycles, one-cycle ready pulse in DONE.
// Backpressure: requester holds valid until ready; valid dropping in RUN or flush aborts to IDLE.
module xc_aessub_seq #(
   parameter int LANES = 1
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        flush,
   input  logic        valid,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic        enc,
   input  logic        rot,
   output logic        ready,
   output logic [31:0] result,
   output logic        busy
);

   localparam int N_STEPS = 4 / LANES;
   localparam int SW      = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state_q;
   logic [SW-1:0]       step_q;
   logic [31:0]         opnd_q;   // gathered source bytes {b3,b2,b1,b0}
   logic                enc_q;
   logic                rot_q;
   logic [31:0]         res_q;
   logic                done_q;
   logic                busy_q;

   logic [31:0]         sh;
   logic [31:0]         win;
   logic [8*LANES-1:0]  lane_out;
   logic [31:0]         lane_mask;
   logic [31:0]         lane_ext;
   logic [31:0]         res_d;
   logic [31:0]         res_rot;

   // Bytes of rs1/rs2 that the instruction does not select.
   logic                unused_bits;
   assign unused_bits = ^{rs1[31:24], rs1[15:8], rs2[23:16], rs2[7:0]};

   // GF(2^8) multiply by x modulo the AES polynomial.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, so every input is defined).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] r;
      sq = a;
      r  = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq = gf_mul(sq, sq);
         r  = gf_mul(r, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] affine(input logic [7:0] a);
      return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
               ^ {a[3:0], a[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_affine(input logic [7:0] a);
      return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   endfunction

   // One lane: the field inverter is shared, only the affine stage differs by direction.
   function automatic logic [7:0] sbox_lane(input logic [7:0] x, input logic e);
      logic [7:0] pre;
      logic [7:0] inv;
      pre = e ? x : inv_affine(x);
      inv = gf_inv(pre);
      return e ? affine(inv) : inv;
   endfunction

   assign sh        = 32'(step_q) * 32'(8 * LANES);
   assign lane_mask = 32'({(8 * LANES){1'b1}});
   assign lane_ext  = 32'(lane_out);
   assign res_d     = (res_q & ~(lane_mask << sh)) | (lane_ext << sh);

   // Select this step's bytes and run them through the S-box lanes.
   always_comb begin
      win      = opnd_q >> sh;
      lane_out = '0;
      for (int l = 0; l < LANES; l++) begin
         lane_out[l*8 +: 8] = sbox_lane(win[l*8 +: 8], enc_q);
      end
   end

   // Control FSM with operand capture and per-step result accumulation.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         opnd_q  <= '0;
         enc_q   <= 1'b0;
         rot_q   <= 1'b0;
         res_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else if (flush) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid) begin
                  opnd_q  <= {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]};
                  enc_q   <= enc;
                  rot_q   <= rot;
                  res_q   <= '0;
                  step_q  <= '0;
                  state_q <= S_RUN;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               if (!valid) begin
                  state_q <= S_IDLE;
                  step_q  <= '0;
                  busy_q  <= 1'b0;
               end else begin
                  res_q <= res_d;
                  if (step_q == SW'(N_STEPS - 1)) begin
                     step_q  <= '0;
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     step_q <= step_q + SW'(1);
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               step_q  <= '0;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Rotation is applied on the way out; result is gated to zero outside the ready pulse.
   assign res_rot = rot_q ? {res_q[23:0], res_q[31:24]} : res_q;
   assign ready   = done_q & ~flush;
   assign result  = ready ? res_rot : 32'h0;
   assign busy    = busy_q;

endmodule
